// File: rtl/pdm_mic_cic_decimator.sv
// pdm_mic_cic_decimator
//   Drives the PDM microphone bit clock and samples the two PDM data lines.
//   Each line goes through a 3rd-order CIC decimator (R = 2^C_DEC_LOG2) and
//   comes out as signed 16-bit PCM. PCM pairs are offered on a valid/ready
//   handshake. All logic runs on CK_i (48 MHz).
//
//   Parameters
//     C_HALF      CK_i cycles per MIC_CK_o half-period (>= 4)
//     C_DEC_LOG2  log2 of the decimation ratio (>= 5)
//
//   Ports
//     CK_i        system clock
//     ARST_i      asynchronous reset, active-high
//     MIC_CK_o    PDM bit clock to both microphones
//     MICs_DAT_i  PDM data, [0] -> channel 0, [1] -> channel 1
//     PCM0s_o     channel 0 sample, signed
//     PCM1s_o     channel 1 sample, signed
//     VALID_o     PCM pair available, held until RDY_i
//     RDY_i       consumer accepts the pair
//     OVR_o       sticky overrun flag (pair overwritten before transfer)
//     OVR_CLR_i   synchronous clear of OVR_o; a simultaneous overrun wins
module pdm_mic_cic_decimator #(
    parameter int C_HALF     = 8,
    parameter int C_DEC_LOG2 = 6
) (
    input  logic               CK_i,
    input  logic               ARST_i,
    output logic               MIC_CK_o,
    input  logic [1:0]         MICs_DAT_i,
    output logic signed [15:0] PCM0s_o,
    output logic signed [15:0] PCM1s_o,
    output logic               VALID_o,
    input  logic               RDY_i,
    output logic               OVR_o,
    input  logic               OVR_CLR_i
);
    localparam int W     = 3 * C_DEC_LOG2 + 2;
    localparam int SHIFT = 3 * C_DEC_LOG2 - 15;
    localparam int CNT_W = (C_HALF > 1) ? $clog2(C_HALF) : 1;

    localparam logic signed [W-1:0] PCM_MAX = W'(32767);
    localparam logic signed [W-1:0] PCM_MIN = W'(-32768);
    localparam logic signed [W-1:0] ONE     = W'(1);
    localparam logic signed [W-1:0] NEG_ONE = W'(-1);

    function automatic logic signed [15:0] scale_sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] s;
        s = v >>> SHIFT;
        if (s > PCM_MAX)      scale_sat = 16'sh7FFF;
        else if (s < PCM_MIN) scale_sat = 16'sh8000;
        else                  scale_sat = s[15:0];
    endfunction

    // ---- bit clock divider; strobe is the cycle before MIC_CK_o falls ----
    logic [CNT_W-1:0] div_cnt;
    logic             div_wrap;
    logic             strobe;

    assign div_wrap = (div_cnt == CNT_W'(C_HALF - 1));
    assign strobe   = div_wrap & MIC_CK_o;

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            div_cnt  <= '0;
            MIC_CK_o <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            MIC_CK_o <= ~MIC_CK_o;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // ---- p0: PDM bits registered on the strobe ----
    logic [1:0] dat_p0;
    logic       vld_p0;

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            dat_p0 <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= strobe;
            if (strobe) dat_p0 <= MICs_DAT_i;
        end
    end

    // ---- p1: integrators, decimation and warm-up counters ----
    logic signed [W-1:0]   int1_p1 [2];
    logic signed [W-1:0]   int2_p1 [2];
    logic signed [W-1:0]   int3_p1 [2];
    logic signed [W-1:0]   int1_nx [2];
    logic signed [W-1:0]   int2_nx [2];
    logic signed [W-1:0]   int3_nx [2];
    logic [C_DEC_LOG2-1:0] dec_cnt;
    logic [1:0]            warm_cnt;
    logic                  dec_last;
    logic                  vld_p1;
    logic                  keep_p1;

    assign dec_last = (dec_cnt == '1);

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            int1_nx[ch] = int1_p1[ch] + (dat_p0[ch] ? ONE : NEG_ONE);
            int2_nx[ch] = int2_p1[ch] + int1_nx[ch];
            int3_nx[ch] = int3_p1[ch] + int2_nx[ch];
        end
    end

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            for (int ch = 0; ch < 2; ch++) begin
                int1_p1[ch] <= '0;
                int2_p1[ch] <= '0;
                int3_p1[ch] <= '0;
            end
            dec_cnt  <= '0;
            warm_cnt <= '0;
            vld_p1   <= 1'b0;
            keep_p1  <= 1'b0;
        end else begin
            vld_p1  <= vld_p0 & dec_last;
            keep_p1 <= vld_p0 & dec_last & (warm_cnt == 2'd3);
            if (vld_p0) begin
                for (int ch = 0; ch < 2; ch++) begin
                    int1_p1[ch] <= int1_nx[ch];
                    int2_p1[ch] <= int2_nx[ch];
                    int3_p1[ch] <= int3_nx[ch];
                end
                dec_cnt <= dec_cnt + 1'b1;
                if (dec_last && warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    // ---- p2..p4: comb stages, one per cycle; discarded events still fill the delays ----
    logic signed [W-1:0] comb1_p2 [2];
    logic signed [W-1:0] dly1_p2  [2];
    logic signed [W-1:0] comb2_p3 [2];
    logic signed [W-1:0] dly2_p3  [2];
    logic signed [W-1:0] comb3_p4 [2];
    logic signed [W-1:0] dly3_p4  [2];
    logic                vld_p2, vld_p3, vld_p4;
    logic                keep_p2, keep_p3, keep_p4;

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            for (int ch = 0; ch < 2; ch++) begin
                comb1_p2[ch] <= '0;
                dly1_p2[ch]  <= '0;
                comb2_p3[ch] <= '0;
                dly2_p3[ch]  <= '0;
                comb3_p4[ch] <= '0;
                dly3_p4[ch]  <= '0;
            end
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            vld_p4  <= 1'b0;
            keep_p2 <= 1'b0;
            keep_p3 <= 1'b0;
            keep_p4 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            vld_p3  <= vld_p2;
            vld_p4  <= vld_p3;
            keep_p2 <= keep_p1;
            keep_p3 <= keep_p2;
            keep_p4 <= keep_p3;
            for (int ch = 0; ch < 2; ch++) begin
                if (vld_p1) begin
                    comb1_p2[ch] <= int3_p1[ch] - dly1_p2[ch];
                    dly1_p2[ch]  <= int3_p1[ch];
                end
                if (vld_p2) begin
                    comb2_p3[ch] <= comb1_p2[ch] - dly2_p3[ch];
                    dly2_p3[ch]  <= comb1_p2[ch];
                end
                if (vld_p3) begin
                    comb3_p4[ch] <= comb2_p3[ch] - dly3_p4[ch];
                    dly3_p4[ch]  <= comb2_p3[ch];
                end
            end
        end
    end

    // ---- p5: scaled output register and handshake ----
    logic load;

    assign load = vld_p4 & keep_p4;

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            PCM0s_o <= '0;
            PCM1s_o <= '0;
            VALID_o <= 1'b0;
            OVR_o   <= 1'b0;
        end else begin
            if (load) begin
                PCM0s_o <= scale_sat(comb3_p4[0]);
                PCM1s_o <= scale_sat(comb3_p4[1]);
                VALID_o <= 1'b1;
            end else if (VALID_o && RDY_i) begin
                VALID_o <= 1'b0;
            end
            if (load && VALID_o && !RDY_i) OVR_o <= 1'b1;
            else if (OVR_CLR_i)            OVR_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_mic_cic_decimator.sv
// Testbench for pdm_mic_cic_decimator: directed phases with constant,
// alternating and random PDM streams, checked against a reference that
// filters the recorded bit stream with the CIC impulse response
// (three convolved length-R boxcars), then scales and saturates.
module tb_pdm_mic_cic_decimator;
    localparam int C_HALF     = 8;
    localparam int C_DEC_LOG2 = 6;
    localparam int R          = 1 << C_DEC_LOG2;
    localparam int HLEN       = 3 * R - 2;
    localparam int SHIFT      = 3 * C_DEC_LOG2 - 15;
    localparam int SPS        = 2 * C_HALF;   // CK_i cycles per PDM sample
    localparam int EVT        = R * SPS;      // CK_i cycles per output pair

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               mic_ck;
    logic [1:0]         dat = 2'b00;
    logic signed [15:0] pcm0;
    logic signed [15:0] pcm1;
    logic               valid;
    logic               rdy = 1'b0;
    logic               ovr;
    logic               ovr_clr = 1'b0;

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;   // CK_i rising edges since reset release
    int     mode     = 0;   // 0: 11, 1: ch0=0 ch1=1, 2: alternating, 3: random
    byte    x0[$];
    byte    x1[$];
    longint h[HLEN];

    pdm_mic_cic_decimator #(
        .C_HALF    (C_HALF),
        .C_DEC_LOG2(C_DEC_LOG2)
    ) dut (
        .CK_i      (clk),
        .ARST_i    (rst),
        .MIC_CK_o  (mic_ck),
        .MICs_DAT_i(dat),
        .PCM0s_o   (pcm0),
        .PCM1s_o   (pcm1),
        .VALID_o   (valid),
        .RDY_i     (rdy),
        .OVR_o     (ovr),
        .OVR_CLR_i (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present the bit for the PDM sample whose strobe edge comes next.
    task automatic drive_data();
        int idx = cyc / SPS;
        while (x0.size() <= idx) begin
            int  n = x0.size();
            byte b0;
            byte b1;
            case (mode)
                0: begin b0 = 1; b1 = 1; end
                1: begin b0 = 0; b1 = 1; end
                2: begin
                    if (n % 2 == 0) b0 = 1; else b0 = 0;
                    b1 = b0;
                end
                default: begin
                    b0 = byte'($urandom_range(0, 1));
                    b1 = byte'($urandom_range(0, 1));
                end
            endcase
            x0.push_back(b0);
            x1.push_back(b1);
        end
        dat = {x1[idx][0], x0[idx][0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drive_data();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        x0.delete();
        x1.delete();
        drive_data();
    endtask

    // Output pair n is the CIC applied to samples 0 .. R*n-1.
    function automatic int model_pcm(input int ch, input int n);
        longint acc = 0;
        longint s;
        for (int k = 0; k < HLEN; k++) begin
            int  j = R * n - 1 - k;
            byte b = (ch == 0) ? x0[j] : x1[j];
            acc += (b != 0) ? h[k] : -h[k];
        end
        s = acc >>> SHIFT;
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    task automatic check_warmup(input string tag);
        for (int n = 1; n <= 3; n++) begin
            run_to(EVT * n + 5);
            check(tag, valid, 0);
        end
    endtask

    // Pair n with RDY_i high: absent the cycle before, present 5 cycles after its strobe.
    task automatic expect_event(input string tag, input int n, input bit use_model,
                                input int e0, input int e1);
        int m0 = e0;
        int m1 = e1;
        run_to(EVT * n + 4);
        check({tag, "_pre"}, valid, 0);
        run_to(EVT * n + 5);
        if (use_model) begin
            m0 = model_pcm(0, n);
            m1 = model_pcm(1, n);
        end
        check({tag, "_valid"}, valid, 1);
        check({tag, "_pcm0"}, pcm0, m0);
        check({tag, "_pcm1"}, pcm1, m1);
    endtask

    initial begin
        for (int k = 0; k < HLEN; k++) h[k] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a + b + c]++;

        // Reset values, bit clock phase, saturation with constant ones
        #1 rst = 1'b1;
        #2;
        check("rst_mic_ck", mic_ck, 0);
        check("rst_valid", valid, 0);
        check("rst_ovr", ovr, 0);
        check("rst_pcm0", pcm0, 0);
        check("rst_pcm1", pcm1, 0);
        mode = 0;
        rdy  = 1'b1;
        release_reset();
        run_to(7);  check("mic_ck_c7", mic_ck, 0);
        run_to(8);  check("mic_ck_c8", mic_ck, 1);
        run_to(15); check("mic_ck_c15", mic_ck, 1);
        run_to(16); check("mic_ck_c16", mic_ck, 0);
        run_to(24); check("mic_ck_c24", mic_ck, 1);
        run_to(32); check("mic_ck_c32", mic_ck, 0);
        check_warmup("sat_warmup");
        expect_event("sat_e4", 4, 1'b0, 32767, 32767);
        run_to(EVT * 4 + 6);
        check("sat_xfer_valid", valid, 0);
        expect_event("sat_e5", 5, 1'b0, 32767, 32767);
        check("sat_ovr", ovr, 0);

        // Polarity and channel split
        #2 rst = 1'b1;
        mode = 1;
        release_reset();
        check_warmup("pol_warmup");
        expect_event("pol_e4", 4, 1'b0, -32768, 32767);
        expect_event("pol_e5", 5, 1'b0, -32768, 32767);

        // Zero mean
        #2 rst = 1'b1;
        mode = 2;
        release_reset();
        for (int n = 4; n <= 6; n++) expect_event("zero", n, 1'b0, 0, 0);

        // Random stream against the reference
        #2 rst = 1'b1;
        mode = 3;
        release_reset();
        check_warmup("rnd_warmup");
        for (int n = 4; n <= 9; n++) expect_event("rnd", n, 1'b1, 0, 0);

        // Backpressure: two pairs without RDY_i
        run_to(EVT * 9 + 6);
        rdy = 1'b0;
        expect_event("bp_e10", 10, 1'b1, 0, 0);
        check("bp_e10_ovr", ovr, 0);
        run_to(EVT * 11 + 5);
        check("bp_e11_valid", valid, 1);
        check("bp_e11_ovr", ovr, 1);
        check("bp_e11_pcm0", pcm0, model_pcm(0, 11));
        check("bp_e11_pcm1", pcm1, model_pcm(1, 11));
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("bp_xfer_valid", valid, 0);
        check("bp_xfer_ovr_sticky", ovr, 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("bp_ovr_clr", ovr, 0);
        run_to(EVT * 12 + 5);
        check("bp_e12_valid", valid, 1);
        check("bp_e12_ovr", ovr, 0);

        // New pair on the same edge as a transfer: no overrun
        run_to(EVT * 13 + 4);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("same_valid", valid, 1);
        check("same_ovr", ovr, 0);
        check("same_pcm0", pcm0, model_pcm(0, 13));
        check("same_pcm1", pcm1, model_pcm(1, 13));

        // Overrun and clear on the same edge: set wins
        run_to(EVT * 14 + 4);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("setwins_ovr", ovr, 1);
        check("setwins_pcm0", pcm0, model_pcm(0, 14));

        // Mid-run reset during the comb pipeline of pair 15
        run_to(EVT * 15 + 2);
        check("mid_pre_valid", valid, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_mic_ck", mic_ck, 0);
        check("mid_rst_ovr", ovr, 0);
        check("mid_rst_pcm0", pcm0, 0);
        rdy = 1'b1;
        release_reset();
        check_warmup("mid_warmup");
        expect_event("mid_e4", 4, 1'b1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
